spi_slave_core: RTL
===================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, defining the word width (range 4..32).
REQ-002 The block SHALL have parameter CPOL, default 0, defining the SCK idle level.
REQ-003 The block SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1, defining shift order.
REQ-005 The block SHALL have parameter SYNC_STAGES, default 2, defining synchronizer depth (minimum 2).
REQ-006 i_clk  in  1  system clock, 50 MHz.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_spi_s_sck / i_spi_s_cs_n / i_spi_s_mosi  in  1 each  SPI pins (CSn active-low).
REQ-009 o_spi_s_miso  out  1  serial data out; o_spi_s_miso_oe  out  1  MISO drive enable.
REQ-010 i_tx_data  in  DATA_W  word to send; i_tx_valid  in  1; o_tx_ready  out  1  holding register empty.
REQ-011 o_rx_data  out  DATA_W  received word; o_rx_valid  out  1; i_rx_ready  in  1  consumer accept.
REQ-012 o_rx_overrun, o_tx_underrun  out  1 each  single-cycle error pulses; o_busy  out  1  CSn asserted (synchronized).

Function
REQ-013 SCK, CSn and MOSI SHALL pass through SYNC_STAGES flops; all logic SHALL use only the synchronized copies and i_clk.
REQ-014 Leading edge SHALL be rising for CPOL=0 and falling for CPOL=1; the sample edge SHALL be the leading edge (CPHA=0) or the trailing edge (CPHA=1); the other edge SHALL be the shift edge.
REQ-015 SCK edges SHALL be ignored while synchronized CSn is high; the supported SCK rate is at most i_clk/8.
REQ-016 The RX shifter SHALL capture MOSI on each sample edge, in MSB- or LSB-first order per MSB_FIRST; a bit counter (width clog2(DATA_W)) SHALL count samples and wrap to 0 after DATA_W.
REQ-017 On the DATA_W-th sample, the word SHALL be copied to o_rx_data and o_rx_valid set on the next i_clk; o_rx_valid SHALL hold until i_rx_ready is high for one cycle.
REQ-018 If a word completes while o_rx_valid is still high and i_rx_ready is low, the new word SHALL overwrite o_rx_data, o_rx_valid SHALL stay high, and o_rx_overrun SHALL pulse for 1 cycle.
REQ-019 A single-word TX holding register SHALL load on i_tx_valid && o_tx_ready; o_tx_ready SHALL be low while it is full.
REQ-020 At word start, the TX shifter SHALL load from the holding register and free it. Word start is the CSn fall for CPHA=0, or the first leading edge of each word for CPHA=1.
REQ-021 If the holding register is empty at word start, the TX shifter SHALL load all zeros and o_tx_underrun SHALL pulse for 1 cycle.
REQ-022 For CPHA=0, the first bit SHALL appear on MISO within 1 clock of synchronized CSn fall, and later bits on each shift edge; for CPHA=1, each bit SHALL update on the leading edge.
REQ-023 o_spi_s_miso_oe SHALL equal the inverse of synchronized CSn, so MISO is released while deselected.
REQ-024 A CSn rise mid-word SHALL clear the bit counter and discard the partial RX word without asserting o_rx_valid. The holding register SHALL be preserved.
REQ-025 A simultaneous holding-register load and word-start transfer SHALL be resolved with the transfer first; the new word SHALL then occupy the holding register.
REQ-026 Multiple words within one CSn frame SHALL be supported back-to-back.

Reset
REQ-027 During reset, all outputs SHALL be 0 (including o_spi_s_miso_oe and o_tx_ready); synchronizers SHALL reset CSn=1, SCK=CPOL, MOSI=0; counters and shifters SHALL be 0.
REQ-028 o_tx_ready SHALL go high on the first clock after reset release.
REQ-029 A reset mid-transfer SHALL abandon the word with no valid or error pulse.

Structure
REQ-030 Package spi_pkg SHALL hold mode constants (MODE0..MODE3 as {CPOL,CPHA}) and the default DATA_W.
REQ-031 One sub-module, spi_sync_edge, SHALL implement the parametrised synchronizer plus rise/fall detect, instantiated once per SPI input.

Verification
REQ-032 Mode 0, 8-bit, tx 0xA5 preloaded; master sends 0x3C -> o_rx_data=0x3C with one o_rx_valid; master reads 0xA5.
REQ-033 Mode 3, LSB-first, DATA_W=16; master sends 0x1234 -> o_rx_data=0x1234; master reads the preloaded 0xBEEF.
REQ-034 Two back-to-back words, i_rx_ready held low -> o_rx_overrun pulses once; o_rx_data holds the second word.
REQ-035 No TX word loaded at CSn fall -> o_tx_underrun pulses once and MISO reads 0x00.
REQ-036 CSn raised after 5 bits, then a full word 0x81 -> no valid for the partial word; o_rx_data=0x81.
REQ-037 i_rst_n asserted mid-word -> all outputs 0 immediately, o_tx_ready=1 one clock after release.

Source files
------------

// File: rtl/spi_pkg.sv
// SPI slave shared definitions: mode encodings ({CPOL,CPHA}) and default word width.
package spi_pkg;

  localparam int SPI_DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  // Clock idle level encoded in a mode constant.
  function automatic logic mode_cpol(input spi_mode_e mode);
    return mode[1];
  endfunction

  // Sampling phase encoded in a mode constant.
  function automatic logic mode_cpha(input spi_mode_e mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall strobes
// derived from the synchronized level (one i_clk wide each).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  // Never fewer than two flops, whatever the caller asks for.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the pin through the synchronizer chain and keep the last level for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core: oversampled SPI pins, RX shifter with one-word output register,
// TX holding register feeding a TX shifter, overrun/underrun pulses.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DEFAULT_DATA_W,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_s_sck,
  input  logic              i_spi_s_cs_n,
  input  logic              i_spi_s_mosi,
  output logic              o_spi_s_miso,
  output logic              o_spi_s_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_rx_overrun,
  output logic              o_tx_underrun,
  output logic              o_busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Bit that goes on the wire first for a given word.
  function automatic logic f_first_bit(input logic [DATA_W-1:0] word);
    return (MSB_FIRST != 0) ? word[DATA_W-1] : word[0];
  endfunction

  // Word with the outgoing bit removed, remaining bits moved toward the output end.
  function automatic logic [DATA_W-1:0] f_advance(input logic [DATA_W-1:0] word);
    return (MSB_FIRST != 0) ? {word[DATA_W-2:0], 1'b0} : {1'b0, word[DATA_W-1:1]};
  endfunction

  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_cs_n, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sync_sck (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_spi_s_sck),
    .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_spi_s_cs_n),
    .o_sync(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_spi_s_mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  // Only SCK edges and the MOSI level matter to the datapath.
  assign w_unused_sync = w_sck_sync ^ w_mosi_rise ^ w_mosi_fall;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx_shift, r_rx_data, r_hold, r_tx_shift;
  logic              r_rx_valid, r_rx_overrun, r_tx_underrun, r_tx_ready;
  logic              r_hold_full, r_pend, r_pend_full, r_miso;

  logic              w_lead, w_trail, w_sample, w_shift, w_cnt_zero;
  logic              w_start, w_peek, w_commit, w_free, w_under, w_tx_load, w_rx_done;
  logic              w_hold_full_nxt;
  logic [DATA_W-1:0] w_rx_next, w_tx_word;

  assign w_lead     = (CPOL == 0) ? w_sck_rise : w_sck_fall;
  assign w_trail    = (CPOL == 0) ? w_sck_fall : w_sck_rise;
  assign w_sample   = ~w_cs_n & ((CPHA == 0) ? w_lead : w_trail);
  assign w_shift    = ~w_cs_n & ((CPHA == 0) ? w_trail : w_lead);
  assign w_cnt_zero = (r_bit_cnt == CNT_ZERO);
  assign w_rx_done  = w_sample & (r_bit_cnt == CNT_LAST);
  assign w_rx_next  = (MSB_FIRST != 0) ? {r_rx_shift[DATA_W-2:0], w_mosi}
                                       : {w_mosi, r_rx_shift[DATA_W-1:1]};

  // Word start: CSn fall in CPHA=0, first leading edge of each word in CPHA=1.
  assign w_start = (CPHA == 0) ? w_cs_fall : (w_shift & w_cnt_zero);
  // CPHA=0 follow-on word: the shift edge after the last sample must already present
  // the next word's first bit, but it may just be the frame's closing edge. The
  // shifter is loaded speculatively and the holding register is only released (or
  // the underrun flagged) once the next word's first sample proves the word is real.
  assign w_peek   = (CPHA == 0) && w_shift && w_cnt_zero && !w_cs_fall;
  assign w_commit = r_pend & w_sample;
  assign w_free   = (w_start & r_hold_full) | (w_commit & r_pend_full);
  assign w_under  = (w_start & ~r_hold_full) | (w_commit & ~r_pend_full);
  // Ready mirrors emptiness, so a load can never coincide with a free of a full register.
  assign w_tx_load       = i_tx_valid & r_tx_ready;
  assign w_hold_full_nxt = (r_hold_full & ~w_free) | w_tx_load;
  assign w_tx_word       = r_hold_full ? r_hold : {DATA_W{1'b0}};

  // Receive path: sample counter, RX shifter and output word with overrun detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt    <= CNT_ZERO;
      r_rx_shift   <= {DATA_W{1'b0}};
      r_rx_data    <= {DATA_W{1'b0}};
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      if (w_cs_n) begin
        r_bit_cnt  <= CNT_ZERO;
        r_rx_shift <= {DATA_W{1'b0}};
      end else if (w_sample) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= (r_bit_cnt == CNT_LAST) ? CNT_ZERO : r_bit_cnt + CNT_W'(1);
      end
      if (w_rx_done) begin
        r_rx_data    <= w_rx_next;
        r_rx_valid   <= 1'b1;
        r_rx_overrun <= r_rx_valid & ~i_rx_ready;
      end else if (i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Transmit path: holding register, speculative reload tracking and MISO shifter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold        <= {DATA_W{1'b0}};
      r_hold_full   <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_tx_shift    <= {DATA_W{1'b0}};
      r_miso        <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_full   <= 1'b0;
    end else begin
      r_tx_underrun <= w_under;
      r_hold_full   <= w_hold_full_nxt;
      r_tx_ready    <= ~w_hold_full_nxt;
      if (w_tx_load) begin
        r_hold <= i_tx_data;
      end
      if (w_cs_n || w_cs_rise) begin
        r_pend      <= 1'b0;
        r_pend_full <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        if (w_peek) begin
          r_pend      <= 1'b1;
          r_pend_full <= r_hold_full;
        end else if (w_commit) begin
          r_pend <= 1'b0;
        end
        if (w_start || w_peek) begin
          r_miso     <= f_first_bit(w_tx_word);
          r_tx_shift <= f_advance(w_tx_word);
        end else if (w_shift) begin
          r_miso     <= f_first_bit(r_tx_shift);
          r_tx_shift <= f_advance(r_tx_shift);
        end
      end
    end
  end

  assign o_spi_s_miso    = r_miso;
  assign o_spi_s_miso_oe = ~w_cs_n;
  assign o_busy          = ~w_cs_n;
  assign o_tx_ready      = r_tx_ready;
  assign o_rx_data       = r_rx_data;
  assign o_rx_valid      = r_rx_valid;
  assign o_rx_overrun    = r_rx_overrun;
  assign o_tx_underrun   = r_tx_underrun;

endmodule
